// File: rtl/des_ahb_pkg.sv
// Shared constants and types for the AHB-Lite front end of the Triple-DES core.
// Register offsets are relative to HADDR[5:0].
package des_ahb_pkg;

   localparam logic [5:0] OFF_KEY1_HI = 6'h00;
   localparam logic [5:0] OFF_KEY1_LO = 6'h04;
   localparam logic [5:0] OFF_KEY2_HI = 6'h08;
   localparam logic [5:0] OFF_KEY2_LO = 6'h0C;
   localparam logic [5:0] OFF_KEY3_HI = 6'h10;
   localparam logic [5:0] OFF_KEY3_LO = 6'h14;
   localparam logic [5:0] OFF_DIN_HI  = 6'h18;
   localparam logic [5:0] OFF_DIN_LO  = 6'h1C;
   localparam logic [5:0] OFF_CTRL    = 6'h20;
   localparam logic [5:0] OFF_STATUS  = 6'h24;
   localparam logic [5:0] OFF_DOUT_HI = 6'h28;
   localparam logic [5:0] OFF_DOUT_LO = 6'h2C;
   localparam logic [5:0] OFF_LIMIT   = 6'h30;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      WAIT,
      ERR1,
      ERR2
   } state_t;

endpackage

// File: rtl/ahb_err_resp.sv
// Two-cycle AHB ERROR response: stall with ERROR, then release with ERROR.
// err_go is asserted in the cycle whose edge enters the first error cycle.
module ahb_err_resp
   import des_ahb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic err_go,
   output logic err_stall,
   output logic err_resp
);

   logic stall_q, stall_d;
   logic resp_q, resp_d;

   always_comb begin
      stall_d = err_go;
      resp_d  = (err_go || stall_q) ? HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 1'b0;
         resp_q  <= HRESP_OKAY;
      end else begin
         stall_q <= stall_d;
         resp_q  <= resp_d;
      end
   end

   assign err_stall = stall_q;
   assign err_resp  = resp_q;

endmodule

// File: rtl/ahb_des_slave.sv
// AHB-Lite slave holding Triple-DES keys, input block, control/status and the
// captured result; DOUT reads stall until the core completes or time out.
module ahb_des_slave
   import des_ahb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [63:0] key1,
   output logic [63:0] key2,
   output logic [63:0] key3,
   output logic [63:0] data_in,
   output logic        decrypt,
   output logic        start,
   input  logic        core_done,
   input  logic [63:0] core_out
);

   state_t             state_q, state_d;
   logic [5:0]         addr_q, addr_d;
   logic               write_q, write_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
   logic [63:0]        din_q, din_d, dout_q, dout_d;
   logic               dec_q, dec_d, busy_q, busy_d, done_q, done_d;
   logic               start_q, start_d;

   logic [5:0]         off_in;
   logic               accept, dout_sel, illegal, done_hit;
   logic               err_stall, err_resp;
   logic               unused_addr;

   assign unused_addr = ^HADDR[31:6];

   always_comb begin
      off_in   = HADDR[5:0];
      dout_sel = (off_in == OFF_DOUT_HI) || (off_in == OFF_DOUT_LO);
      accept   = HSEL && HREADY && (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ})
                 && (state_q inside {IDLE, DATA, ERR2});
      illegal  = (HSIZE != HSIZE_WORD) || (off_in[1:0] != 2'b00) || (off_in >= OFF_LIMIT)
                 || (HWRITE && ((off_in == OFF_STATUS) || dout_sel))
                 || (HWRITE && busy_q && (off_in <= OFF_CTRL));
      done_hit = core_done && busy_q;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      cnt_d   = '0;
      key1_d  = key1_q;
      key2_d  = key2_q;
      key3_d  = key3_q;
      din_d   = din_q;
      dout_d  = dout_q;
      dec_d   = dec_q;
      busy_d  = busy_q;
      done_d  = done_q;
      start_d = 1'b0;

      if (done_hit) begin
         dout_d = core_out;
         busy_d = 1'b0;
         done_d = 1'b1;
      end

      // Data-phase writes come after the completion update so a start wins.
      if (state_q == DATA && write_q) begin
         case (addr_q)
            OFF_KEY1_HI: key1_d[63:32] = HWDATA;
            OFF_KEY1_LO: key1_d[31:0]  = HWDATA;
            OFF_KEY2_HI: key2_d[63:32] = HWDATA;
            OFF_KEY2_LO: key2_d[31:0]  = HWDATA;
            OFF_KEY3_HI: key3_d[63:32] = HWDATA;
            OFF_KEY3_LO: key3_d[31:0]  = HWDATA;
            OFF_DIN_HI:  din_d[63:32]  = HWDATA;
            OFF_DIN_LO:  din_d[31:0]   = HWDATA;
            OFF_CTRL: begin
               dec_d = HWDATA[1];
               if (HWDATA[0]) begin
                  start_d = 1'b1;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      case (state_q)
         WAIT: begin
            if (done_hit) begin
               state_d = DATA;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ERR1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ERR1: state_d = ERR2;
         default: begin
            if (accept) begin
               addr_d  = off_in;
               write_d = HWRITE;
               if (illegal)
                  state_d = ERR1;
               else if (!HWRITE && dout_sel && busy_q && !core_done)
                  state_d = WAIT;
               else
                  state_d = DATA;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
         key1_q  <= '0;
         key2_q  <= '0;
         key3_q  <= '0;
         din_q   <= '0;
         dout_q  <= '0;
         dec_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         key1_q  <= key1_d;
         key2_q  <= key2_d;
         key3_q  <= key3_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         dec_q   <= dec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         start_q <= start_d;
      end
   end

   ahb_err_resp u_err (
      .clk       (HCLK),
      .rst       (HRESET),
      .err_go    (state_d == ERR1),
      .err_stall (err_stall),
      .err_resp  (err_resp)
   );

   always_comb begin
      HRDATA = '0;
      if (state_q == DATA && !write_q) begin
         case (addr_q)
            OFF_KEY1_HI: HRDATA = key1_q[63:32];
            OFF_KEY1_LO: HRDATA = key1_q[31:0];
            OFF_KEY2_HI: HRDATA = key2_q[63:32];
            OFF_KEY2_LO: HRDATA = key2_q[31:0];
            OFF_KEY3_HI: HRDATA = key3_q[63:32];
            OFF_KEY3_LO: HRDATA = key3_q[31:0];
            OFF_DIN_HI:  HRDATA = din_q[63:32];
            OFF_DIN_LO:  HRDATA = din_q[31:0];
            OFF_CTRL:    HRDATA = {30'b0, dec_q, 1'b0};
            OFF_STATUS:  HRDATA = {30'b0, done_q, busy_q};
            OFF_DOUT_HI: HRDATA = dout_q[63:32];
            OFF_DOUT_LO: HRDATA = dout_q[31:0];
            default:     HRDATA = '0;
         endcase
      end
   end

   assign HREADYOUT = (state_q != WAIT) && !err_stall;
   assign HRESP     = err_resp;
   assign key1      = key1_q;
   assign key2      = key2_q;
   assign key3      = key3_q;
   assign data_in   = din_q;
   assign decrypt   = dec_q;
   assign start     = start_q;

endmodule

// File: tb/tb_ahb_des_slave.sv
// Randomized bench for ahb_des_slave against a transaction-level register model.
module tb_ahb_des_slave;
   import des_ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [63:0] key1, key2, key3, data_in, core_out;
   logic        decrypt, start, core_done;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_word [0:7];
   logic        m_dec, m_busy, m_done;
   logic [63:0] m_dout;

   logic [31:0] last_rdata;
   int unsigned last_stalls;

   always #5 HCLK = ~HCLK;

   ahb_des_slave #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .key1(key1), .key2(key2), .key3(key3), .data_in(data_in),
      .decrypt(decrypt), .start(start), .core_done(core_done), .core_out(core_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_word[i] = '0;
      m_dec = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_dout = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [5:0] off);
      case (off)
         6'h20:   return {30'b0, m_dec, 1'b0};
         6'h24:   return {30'b0, m_done, m_busy};
         6'h28:   return m_dout[63:32];
         6'h2C:   return m_dout[31:0];
         default: return m_word[off[4:2]];
      endcase
   endfunction

   task automatic check_outputs();
      check("key1", key1, {m_word[0], m_word[1]});
      check("key2", key2, {m_word[2], m_word[3]});
      check("key3", key3, {m_word[4], m_word[5]});
      check("data_in", data_in, {m_word[6], m_word[7]});
      check("decrypt", decrypt, m_dec);
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic xfer(input logic wr, input logic [5:0] off, input logic [2:0] size,
                       input logic [31:0] wdata, input int unsigned done_after,
                       input logic [63:0] cout);
      logic illegal, waits, fin, fresp, exp_start, post_start, start_after;
      logic [31:0] frdata;
      int unsigned stalls, resp_hi, start_hi;

      illegal = (size != 3'b010) || (off[1:0] != 2'b00) || (off >= 6'h30) ||
                (wr && off >= 6'h24) || (wr && m_busy);
      waits   = !illegal && !wr && (off == 6'h28 || off == 6'h2C) && m_busy;
      exp_start = 1'b0;

      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HSIZE = size;
      HADDR = ($urandom_range(0, 32'h4F) << 6) | {26'b0, off};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wdata;

      stalls = 0; resp_hi = 0; start_hi = 0; fin = 1'b0; fresp = 1'b0; frdata = '0;
      for (int k = 1; k <= 300 && !fin; k++) begin
         core_done = waits && (done_after != 0) && (k == done_after);
         core_out  = cout;
         @(negedge HCLK);
         if (start) start_hi++;
         if (HREADYOUT) begin
            fin = 1'b1; fresp = HRESP; frdata = HRDATA;
         end else begin
            stalls++;
            if (HRESP) resp_hi++;
         end
         @(posedge HCLK); #1;
      end
      core_done = 1'b0;
      check("xfer_completes", fin, 1'b1);

      if (illegal) begin
         check("err_stalls", stalls, 1);
         check("err_resp_cycle1", resp_hi, 1);
         check("err_resp_cycle2", fresp, 1'b1);
         check("err_rdata", frdata, 32'h0);
      end else if (waits && done_after == 0) begin
         check("timeout_stalls", stalls, 65);
         check("timeout_resp_stall", resp_hi, 1);
         check("timeout_resp_final", fresp, 1'b1);
         check("timeout_rdata", frdata, 32'h0);
      end else begin
         if (waits) begin
            m_dout = cout; m_busy = 1'b0; m_done = 1'b1;
         end
         check("ok_stalls", stalls, waits ? done_after : 0);
         check("ok_resp_stall", resp_hi, 0);
         check("ok_resp", fresp, 1'b0);
         if (!wr) begin
            check("rdata", frdata, m_read(off));
         end else if (off < 6'h20) begin
            m_word[off[4:2]] = wdata;
         end else begin
            m_dec = wdata[1];
            if (wdata[0]) begin
               m_busy = 1'b1; m_done = 1'b0; exp_start = 1'b1;
            end
         end
      end
      last_rdata  = frdata;
      last_stalls = stalls;

      @(negedge HCLK); post_start = start;
      @(posedge HCLK); #1;
      @(negedge HCLK); start_after = start;
      @(posedge HCLK); #1;
      check("start_during_xfer", start_hi, 0);
      check("start_pulse", post_start, exp_start);
      check("start_width", start_after, 1'b0);
      check_outputs();
   endtask

   task automatic pulse_done(input logic [63:0] cout);
      core_done = 1'b1; core_out = cout;
      @(posedge HCLK); #1;
      core_done = 1'b0;
      if (m_busy) begin
         m_dout = cout; m_busy = 1'b0; m_done = 1'b1;
      end
   endtask

   // Address phases that must be ignored: not selected, or BUSY/IDLE transfers.
   task automatic ignored_xfer(input logic sel, input logic [1:0] trans);
      HSEL = sel; HTRANS = trans; HWRITE = 1'b1; HSIZE = 3'b010;
      HADDR = 32'h0000_0000;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = $urandom;
      @(negedge HCLK);
      check("ignored_ready", HREADYOUT, 1'b1);
      check("ignored_resp", HRESP, 1'b0);
      @(posedge HCLK); #1;
      check_outputs();
   endtask

   initial begin
      logic [5:0]  off;
      logic [2:0]  size;
      logic        wr;
      logic [31:0] wdata;

      HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
      HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; core_done = 1'b0; core_out = '0;
      model_reset();
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_hreadyout", HREADYOUT, 1'b1);
      check("rst_hresp", HRESP, 1'b0);
      check("rst_start", start, 1'b0);
      check("rst_hrdata", HRDATA, 32'h0);
      check_outputs();
      HRESET = 1'b0;
      @(posedge HCLK); #1;

      // key write and readback
      xfer(1'b1, 6'h00, 3'b010, 32'h0123_4567, 0, '0);
      xfer(1'b1, 6'h04, 3'b010, 32'h89AB_CDEF, 0, '0);
      check("key1_value", key1, 64'h0123_4567_89AB_CDEF);
      xfer(1'b0, 6'h00, 3'b010, '0, 0, '0);
      check("key1_hi_read", last_rdata, 32'h0123_4567);
      xfer(1'b0, 6'h04, 3'b010, '0, 0, '0);
      check("key1_lo_read", last_rdata, 32'h89AB_CDEF);

      // encryption launch and completion
      xfer(1'b1, 6'h18, 3'b010, 32'h1111_2222, 0, '0);
      xfer(1'b1, 6'h1C, 3'b010, 32'h3333_4444, 0, '0);
      xfer(1'b1, 6'h20, 3'b010, 32'h0000_0003, 0, '0);
      check("decrypt_set", decrypt, 1'b1);
      xfer(1'b0, 6'h24, 3'b010, '0, 0, '0);
      check("status_busy", last_rdata, 32'h1);
      pulse_done(64'hDEAD_BEEF_CAFE_F00D);
      xfer(1'b0, 6'h24, 3'b010, '0, 0, '0);
      check("status_done", last_rdata, 32'h2);
      xfer(1'b0, 6'h28, 3'b010, '0, 0, '0);
      check("dout_hi", last_rdata, 32'hDEAD_BEEF);
      pulse_done(64'h5555_5555_5555_5555);
      xfer(1'b0, 6'h28, 3'b010, '0, 0, '0);
      check("done_ignored_idle", last_rdata, 32'hDEAD_BEEF);

      // stalled DOUT read released by completion
      xfer(1'b1, 6'h20, 3'b010, 32'h0000_0001, 0, '0);
      xfer(1'b0, 6'h2C, 3'b010, '0, 5, 64'h0123_4567_CAFE_F00D);
      check("wait_stalls", last_stalls, 5);
      check("wait_rdata", last_rdata, 32'hCAFE_F00D);

      // illegal accesses while busy
      xfer(1'b1, 6'h20, 3'b010, 32'h0000_0001, 0, '0);
      xfer(1'b1, 6'h0C, 3'b010, 32'hFFFF_FFFF, 0, '0);
      xfer(1'b1, 6'h24, 3'b010, 32'hFFFF_FFFF, 0, '0);
      xfer(1'b0, 6'h00, 3'b000, '0, 0, '0);
      xfer(1'b0, 6'h32, 3'b010, '0, 0, '0);
      xfer(1'b0, 6'h30, 3'b010, '0, 0, '0);
      xfer(1'b0, 6'h24, 3'b010, '0, 0, '0);
      check("status_still_busy", last_rdata, 32'h1);
      ignored_xfer(1'b1, HTRANS_BUSY);
      ignored_xfer(1'b1, HTRANS_IDLE);
      ignored_xfer(1'b0, HTRANS_NONSEQ);

      // timeout of a stalled DOUT read
      xfer(1'b0, 6'h2C, 3'b010, '0, 0, '0);

      // reset arriving during a stalled read
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = 32'h2C;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      repeat (10) @(posedge HCLK);
      #1;
      check("midwait_stalled", HREADYOUT, 1'b0);
      #2 HRESET = 1'b1;
      #1;
      check("midwait_rst_ready", HREADYOUT, 1'b1);
      check("midwait_rst_resp", HRESP, 1'b0);
      check("midwait_rst_start", start, 1'b0);
      check("midwait_rst_key1", key1, 64'h0);
      check("midwait_rst_rdata", HRDATA, 32'h0);
      model_reset();
      check_outputs();
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      xfer(1'b0, 6'h24, 3'b010, '0, 0, '0);
      check("status_after_rst", last_rdata, 32'h0);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         off  = 6'($urandom_range(0, 11) * 4);
         size = 3'b010;
         wr   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         case ($urandom_range(0, 9))
            0: begin size = 3'($urandom_range(0, 7)); if (size == 3'b010) size = 3'b001; end
            1: off = off | 6'($urandom_range(1, 3));
            2: off = 6'($urandom_range(12, 15) * 4);
            default: ;
         endcase
         if (wr && off == 6'h20 && $urandom_range(0, 1) == 1) wdata[0] = 1'b1;
         xfer(wr, off, size, wdata, $urandom_range(1, 8), {$urandom, $urandom});
         if ($urandom_range(0, 9) < 3) pulse_done({$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_des_slave.md
Name: ahb_des_slave

Overview:
AHB-Lite slave that fronts the Triple-DES core in the 0x0000_0000–0x0000_13FF window (the address-decoded slave 0 region). It holds three 64-bit keys, the 64-bit input block, control and status, and the captured 64-bit result. It launches the core with a single-cycle start, stalls DOUT reads with wait states until the core finishes, and returns two-cycle ERROR responses for illegal accesses.

Parameters:
TIMEOUT_CYCLES, 64, max wait-state cycles on a stalled DOUT read before ERROR
CNT_W, 7, width of the wait counter (must hold TIMEOUT_CYCLES)

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous reset, active-high
HSEL  in  1  slave select from address decode (1 = this slave)
HADDR  in  32  address; only [5:0] used for the register index
HWRITE  in  1  1 = write
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HSIZE  in  3  only 3'b010 (word) is legal
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
key1, key2, key3  out  64 each  key registers to the core
data_in  out  64  input block to the core
decrypt  out  1  CTRL[1]
start  out  1  one-cycle launch pulse
core_done  in  1  one-cycle completion pulse from the core
core_out  in  64  core result, valid while core_done=1

Behaviour:
- Register map (offset = HADDR[5:0]): 0x00/0x04 KEY1 hi/lo, 0x08/0x0C KEY2, 0x10/0x14 KEY3, 0x18/0x1C DIN hi/lo, 0x20 CTRL (bit0 START write-1, reads 0; bit1 DECRYPT), 0x24 STATUS (RO: bit0 BUSY, bit1 DONE), 0x28/0x2C DOUT hi/lo (RO).
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. The slave registers the address, write flag and a valid bit. BUSY and IDLE transfers get zero-wait OKAY responses with no effect.
- The error check is evaluated at the address phase. Any of the following gives ERROR and leaves all register state unchanged:
  - HSIZE != 010
  - HADDR[1:0] != 0
  - offset >= 0x30
  - a write to STATUS or DOUT
  - a write to KEY, DIN or CTRL while BUSY=1
- ERROR response, two cycles:
  - cycle 1: HREADYOUT=0, HRESP=1
  - cycle 2: HREADYOUT=1, HRESP=1
- FSM states:
  - IDLE: no data phase pending.
  - DATA: zero-wait data phase, HREADYOUT=1.
  - WAIT: stalled DOUT read.
  - ERR1, ERR2: the two error cycles.
  - From IDLE, DATA or ERR2, a new accepted address goes to DATA, WAIT (DOUT read with BUSY=1), or ERR1 (illegal). With no new address, the FSM goes to IDLE.
  - ERR1 goes to ERR2.
- Writes: HWDATA is captured at the end of the data-phase cycle and is visible from the next cycle.
- A CTRL write with bit0=1 behaves as follows:
  - start=1 for exactly the cycle after the data phase.
  - BUSY=1 and DONE=0 from that same cycle.
  - DECRYPT is updated in the same write.
- Reads: HRDATA shows the selected register during a completing data phase and is 0 otherwise.
- WAIT: HREADYOUT=0 while the wait counter increments each cycle.
  - core_done=1: DOUT is loaded and the FSM goes to DATA, which returns the new value.
  - Counter reaches TIMEOUT_CYCLES: the FSM goes to ERR1 and the counter clears.
- core_done with BUSY=1: DOUT ← core_out, BUSY=0, DONE=1, all in the same edge. core_done with BUSY=0 is ignored.
- If core_done and a start write coincide, start wins the next cycle (BUSY=1, DONE=0).
- Reset, which may arrive mid-transfer or mid-WAIT, forces all of the following:
  - all registers and outputs to 0
  - HREADYOUT=1, HRESP=0, start=0
  - FSM to IDLE
  - wait counter to 0

Decomposition:
- Package des_ahb_pkg holds:
  - register offset localparams
  - HTRANS, HSIZE_WORD and HRESP constants
  - the state enum typedef (IDLE, DATA, WAIT, ERR1, ERR2)
- One sub-module, ahb_err_resp, generates the two-cycle ERROR sequence. All other logic lives inside ahb_des_slave.

Test Plan:
- Reset, then write KEY1_HI=0x01234567 and KEY1_LO=0x89ABCDEF, then read both back: zero-wait OKAY and key1=0x0123456789ABCDEF.
- Write DIN, then CTRL=0x3: start is high for 1 cycle, decrypt=1, STATUS reads 0x1. Then core_done with core_out=0xDEADBEEFCAFEF00D: STATUS=0x2, DOUT_HI=0xDEADBEEF.
- Read DOUT_LO while BUSY, with core_done arriving 5 cycles later: HREADYOUT=0 for 5 cycles, then HRDATA=0xCAFEF00D with OKAY.
- Write KEY2_LO while BUSY, write STATUS, HSIZE=byte, and HADDR=0x32: each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles, and registers are unchanged.
- DOUT read while BUSY with no core_done: after 64 wait cycles, a two-cycle ERROR. Assert HRESET during WAIT: outputs return to reset values immediately.
